// File: rtl/fragment_writer.sv
// -----------------------------------------------------------------------------
// fragment_writer
// Accepts one pixel fragment at a time, clamps its 16.16 depth and colour
// components, optionally performs a LESS depth test against the stored depth,
// and issues the depth write and the colour write to the framebuffer.
//
// Ports
//   clk, rst                 : single clock, asynchronous active-high reset
//   frag_valid / frag_ready  : fragment handshake (ready only while idle)
//   frag_x, frag_y           : unsigned pixel coordinates
//   frag_z/r/g/b             : signed 16.16 fixed-point depth and colour
//   depth_test_en            : enable LESS depth test, sampled on accept
//   zrd_req/gnt/addr         : depth read request, held until granted
//   zrd_valid/data           : depth read return, variable latency
//   zwr_en/addr/data         : single-cycle depth write
//   cwr_req/ack/addr/data    : colour write {R8,G8,B8}, held until acked
//   busy                     : a fragment is in flight
//   pass_cnt, rej_cnt        : saturating pass / reject counters
// -----------------------------------------------------------------------------
module fragment_writer #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frag_valid,
    output logic              frag_ready,
    input  logic [9:0]        frag_x,
    input  logic [9:0]        frag_y,
    input  logic [31:0]       frag_z,
    input  logic [31:0]       frag_r,
    input  logic [31:0]       frag_g,
    input  logic [31:0]       frag_b,
    input  logic              depth_test_en,
    output logic              zrd_req,
    input  logic              zrd_gnt,
    output logic [ADDR_W-1:0] zrd_addr,
    input  logic              zrd_valid,
    input  logic [15:0]       zrd_data,
    output logic              zwr_en,
    output logic [ADDR_W-1:0] zwr_addr,
    output logic [15:0]       zwr_data,
    output logic              cwr_req,
    input  logic              cwr_ack,
    output logic [ADDR_W-1:0] cwr_addr,
    output logic [23:0]       cwr_data,
    output logic              busy,
    output logic [15:0]       pass_cnt,
    output logic [15:0]       rej_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ZREAD  = 3'd1,
        ZWAIT  = 3'd2,
        TEST   = 3'd3,
        CWRITE = 3'd4
    } state_t;

    localparam logic [31:0]       FB_W_U = FB_WIDTH;
    localparam logic [31:0]       FB_H_U = FB_HEIGHT;
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_WIDTH);

    // Clamp a signed 16.16 value to an unsigned 0.16 depth:
    // negative -> 0, 1.0 or above -> all ones, else the fraction bits.
    function automatic logic [15:0] clamp_z(input logic [31:0] v);
        logic [15:0] res;
        if (v[31]) begin
            res = 16'h0000;
        end else if (v[30:16] != 15'd0) begin
            res = 16'hFFFF;
        end else begin
            res = v[15:0];
        end
        return res;
    endfunction

    // Colour uses the same saturation, keeping the top 8 fraction bits.
    function automatic logic [7:0] clamp_c(input logic [31:0] v);
        logic [15:0] full;
        full = clamp_z(v);
        return full[15:8];
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         z_q, z_d;
    logic [23:0]         color_q, color_d;
    logic                test_en_q, test_en_d;
    logic [15:0]         zstore_q, zstore_d;
    logic [15:0]         pass_cnt_q, pass_cnt_d;
    logic [15:0]         rej_cnt_q, rej_cnt_d;

    logic                oob_s;
    logic [ADDR_W-1:0]   addr_calc_s;
    logic                z_less_s;
    logic                pass_inc_s;
    logic                rej_inc_s;

    assign oob_s       = ({22'd0, frag_x} >= FB_W_U) || ({22'd0, frag_y} >= FB_H_U);
    assign addr_calc_s = ADDR_W'(frag_y) * FB_W_A + ADDR_W'(frag_x);
    assign z_less_s    = (z_q < zstore_q);

    // Next-state, fragment capture and counter-increment decisions.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        z_d        = z_q;
        color_d    = color_q;
        test_en_d  = test_en_q;
        zstore_d   = zstore_q;
        pass_inc_s = 1'b0;
        rej_inc_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frag_valid) begin
                    if (oob_s) begin
                        // Off-screen fragments are dropped without memory traffic.
                        rej_inc_s = 1'b1;
                    end else begin
                        addr_d    = addr_calc_s;
                        z_d       = clamp_z(frag_z);
                        color_d   = {clamp_c(frag_r), clamp_c(frag_g), clamp_c(frag_b)};
                        test_en_d = depth_test_en;
                        state_d   = depth_test_en ? ZREAD : CWRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ZREAD: begin
                // Any zrd_valid coinciding with the grant is not ours; ignore it.
                if (zrd_gnt) begin
                    state_d = ZWAIT;
                end else begin
                    state_d = ZREAD;
                end
            end
            ZWAIT: begin
                if (zrd_valid) begin
                    zstore_d = zrd_data;
                    state_d  = TEST;
                end else begin
                    state_d = ZWAIT;
                end
            end
            TEST: begin
                if (z_less_s) begin
                    state_d = CWRITE;
                end else begin
                    rej_inc_s = 1'b1;
                    state_d   = IDLE;
                end
            end
            CWRITE: begin
                if (cwr_ack) begin
                    pass_inc_s = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = CWRITE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating pass / reject counters.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        rej_cnt_d  = rej_cnt_q;
        if (pass_inc_s && (pass_cnt_q != 16'hFFFF)) begin
            pass_cnt_d = pass_cnt_q + 16'd1;
        end else begin
            pass_cnt_d = pass_cnt_q;
        end
        if (rej_inc_s && (rej_cnt_q != 16'hFFFF)) begin
            rej_cnt_d = rej_cnt_q + 16'd1;
        end else begin
            rej_cnt_d = rej_cnt_q;
        end
    end

    // State, fragment and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            z_q        <= 16'h0000;
            color_q    <= 24'h000000;
            test_en_q  <= 1'b0;
            zstore_q   <= 16'h0000;
            pass_cnt_q <= 16'h0000;
            rej_cnt_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            z_q        <= z_d;
            color_q    <= color_d;
            test_en_q  <= test_en_d;
            zstore_q   <= zstore_d;
            pass_cnt_q <= pass_cnt_d;
            rej_cnt_q  <= rej_cnt_d;
        end
    end

    // Outputs decode the state register; address/data come straight from the
    // captured fragment so they stay stable while a request is outstanding.
    assign frag_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign zrd_req    = (state_q == ZREAD);
    assign zwr_en     = (state_q == TEST) && z_less_s && test_en_q;
    assign cwr_req    = (state_q == CWRITE);
    assign zrd_addr   = addr_q;
    assign zwr_addr   = addr_q;
    assign cwr_addr   = addr_q;
    assign zwr_data   = z_q;
    assign cwr_data   = color_q;
    assign pass_cnt   = pass_cnt_q;
    assign rej_cnt    = rej_cnt_q;

endmodule
